// File: rtl/bus_stim_pkg.sv
// bus_stim_pkg: shared types and helpers for the bus stimulus sequencer.
//   seq_state_e : playback FSM states
//   beat_w()    : width of one stored beat {wr, addr}
package bus_stim_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

    function automatic int beat_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/bus_stim_if.sv
// bus_stim_if: en/wr/addr beat bus with ready backpressure.
//   en    : beat valid (master -> slave)
//   wr    : write (1) / read (0) (master -> slave)
//   addr  : beat address (master -> slave)
//   ready : slave accepts the current beat (slave -> master)
interface bus_stim_if #(
    parameter int ADDR_W = 6
) ();

    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              ready;

    modport master (output en, wr, addr, input ready);
    modport slave  (input en, wr, addr, output ready);

endinterface

// File: rtl/bus_stim_table.sv
// bus_stim_table: DEPTH x {wr, addr} register file holding the beat table.
//   clk, rst  : clock, synchronous active-high clear of every entry
//   we_i      : write strobe for entry wr_idx_i with wdata_i
//   rd_idx_i  : combinational read index, rdata_o is that entry
module bus_stim_table
    import bus_stim_pkg::*;
#(
    parameter  int ADDR_W = 6,
    parameter  int DEPTH  = 8,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int BW     = beat_w(ADDR_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [BW-1:0]    wdata_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [BW-1:0]    rdata_o
);

    logic [BW-1:0] mem_q [DEPTH];

    // Per-entry decode: an index beyond DEPTH matches no entry and is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst)
                mem_q[i] <= '0;
            else if (we_i && wr_idx_i == IDX_W'(i))
                mem_q[i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_idx_i];

endmodule

// File: rtl/bus_stim_sequencer.sv
// bus_stim_sequencer: plays a programmable table of {wr, addr} beats onto an en/wr/addr bus.
//   clk, rst         : clock, synchronous active-high reset
//   prog_we_i/idx/wr/addr : table write port, honoured only outside RUN
//   num_beats_i      : beats per pass (clamped to DEPTH), sampled on start
//   loop_en_i        : wrap to entry 0 after the last beat, sampled on start
//   start_i, stop_i  : launch playback from IDLE, abort playback
//   bus              : master side of the beat bus (en/wr/addr out, ready in)
//   busy_o, done_o   : high in RUN, one-cycle pulse at end of pass or abort
module bus_stim_sequencer
    import bus_stim_pkg::*;
#(
    parameter  int ADDR_W = 6,
    parameter  int DEPTH  = 8,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we_i,
    input  logic [IDX_W-1:0]  prog_idx_i,
    input  logic              prog_wr_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [CNT_W-1:0]  num_beats_i,
    input  logic              loop_en_i,
    input  logic              start_i,
    input  logic              stop_i,
    bus_stim_if.master        bus,
    output logic              busy_o,
    output logic              done_o
);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic              loop_q, loop_d;
    logic              en_q, en_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rd_beat;
    logic              last;

    // Reads at idx_d so the registered outputs carry the beat for the coming cycle.
    bus_stim_table #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_table (
        .clk      (clk),
        .rst      (rst),
        .we_i     (prog_we_i && state_q != RUN),
        .wr_idx_i (prog_idx_i),
        .wdata_i  ({prog_wr_i, prog_addr_i}),
        .rd_idx_i (idx_d),
        .rdata_o  (rd_beat)
    );

    assign last = CNT_W'(idx_q) == n_q - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            loop_q  <= 1'b0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            loop_q  <= loop_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        loop_d  = loop_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (num_beats_i != '0) ? RUN : DONE;
                    n_d     = (num_beats_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_beats_i;
                    loop_d  = loop_en_i;
                    idx_d   = '0;
                end
            end
            RUN: begin
                // A beat accepted together with stop is simply the final beat.
                if (stop_i)
                    state_d = DONE;
                else if (bus.ready) begin
                    idx_d   = last ? '0 : idx_q + IDX_W'(1);
                    state_d = (last && !loop_q) ? DONE : RUN;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        en_d   = state_d == RUN;
        busy_d = en_d;
        done_d = state_d == DONE;
        wr_d   = en_d ? rd_beat[ADDR_W] : 1'b0;
        addr_d = en_d ? rd_beat[ADDR_W-1:0] : '0;
    end

    assign bus.en   = en_q;
    assign bus.wr   = wr_q;
    assign bus.addr = addr_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_bus_stim_sequencer.sv
// tb_bus_stim_sequencer: scoreboard bench for bus_stim_sequencer (default and ADDR_W=10/DEPTH=16).
module tb_bus_stim_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic       prog_we0 = 1'b0, prog_wr0 = 1'b0, loop0 = 1'b0, start0 = 1'b0, stop0 = 1'b0;
    logic [2:0] prog_idx0 = '0;
    logic [5:0] prog_addr0 = '0;
    logic [3:0] num0 = '0;
    logic       busy0, done0;

    logic       prog_we1 = 1'b0, prog_wr1 = 1'b0, start1 = 1'b0;
    logic [3:0] prog_idx1 = '0;
    logic [9:0] prog_addr1 = '0;
    logic [4:0] num1 = '0;
    logic       busy1, done1;

    bus_stim_if #(.ADDR_W(6))  b0 ();
    bus_stim_if #(.ADDR_W(10)) b1 ();

    bus_stim_sequencer u0 (
        .clk(clk), .rst(rst),
        .prog_we_i(prog_we0), .prog_idx_i(prog_idx0), .prog_wr_i(prog_wr0), .prog_addr_i(prog_addr0),
        .num_beats_i(num0), .loop_en_i(loop0), .start_i(start0), .stop_i(stop0),
        .bus(b0), .busy_o(busy0), .done_o(done0)
    );

    bus_stim_sequencer #(.ADDR_W(10), .DEPTH(16)) u1 (
        .clk(clk), .rst(rst),
        .prog_we_i(prog_we1), .prog_idx_i(prog_idx1), .prog_wr_i(prog_wr1), .prog_addr_i(prog_addr1),
        .num_beats_i(num1), .loop_en_i(1'b0), .start_i(start1), .stop_i(1'b0),
        .bus(b1), .busy_o(busy1), .done_o(done1)
    );

    int n_chk = 0, n_fail = 0;
    int q0[$], q1[$];
    int held0 = 0, held1 = 0;
    bit stall0 = 1'b0, stall1 = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard monitors: every accepted beat must be the next expected one,
    // and a stalled beat must not change while it waits.
    always @(negedge clk) begin
        if (!rst && b0.en) begin
            if (stall0) check("hold0", int'({b0.wr, b0.addr}), held0);
            if (b0.ready) begin
                if (q0.size() == 0) check("extra_beat0", int'({b0.wr, b0.addr}), -1);
                else check("beat0", int'({b0.wr, b0.addr}), q0.pop_front());
            end
            stall0 = !b0.ready;
            held0  = int'({b0.wr, b0.addr});
        end else stall0 = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst && b1.en) begin
            if (stall1) check("hold1", int'({b1.wr, b1.addr}), held1);
            if (b1.ready) begin
                if (q1.size() == 0) check("extra_beat1", int'({b1.wr, b1.addr}), -1);
                else check("beat1", int'({b1.wr, b1.addr}), q1.pop_front());
            end
            stall1 = !b1.ready;
            held1  = int'({b1.wr, b1.addr});
        end else stall1 = 1'b0;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic prog0(input int i, input int w, input int a);
        prog_idx0 = 3'(i); prog_wr0 = 1'(w); prog_addr0 = 6'(a); prog_we0 = 1'b1;
        tick();
        prog_we0 = 1'b0;
    endtask

    task automatic prog1(input int i, input int w, input int a);
        prog_idx1 = 4'(i); prog_wr1 = 1'(w); prog_addr1 = 10'(a); prog_we1 = 1'b1;
        tick();
        prog_we1 = 1'b0;
    endtask

    task automatic exp0(input int w, input int a);
        q0.push_back(w * 64 + a);
    endtask

    task automatic go0(input int n, input bit lp);
        num0 = 4'(n); loop0 = lp; start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input string nm, input int exp);
        int c = 0;
        do begin
            tick();
            c++;
        end while (!done0 && c < 40);
        check(nm, c, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        b0.ready = 1'b1;
        b1.ready = 1'b1;
        tick(2);
        check("rst_bus0", int'({b0.en, b0.wr, b0.addr}), 0);
        check("rst_busy_done0", int'({busy0, done0}), 0);
        rst = 1'b0;
        tick();

        // Single-shot playback
        prog0(0, 1, 12); prog0(1, 1, 14); prog0(2, 0, 23); prog0(3, 0, 48);
        exp0(1, 12); exp0(1, 14); exp0(0, 23); exp0(0, 48);
        go0(4, 1'b0);
        check("t1_first", int'({b0.en, busy0, b0.wr, b0.addr}), 256 + 128 + 64 + 12);
        wait_done0("t1_done_latency", 4);
        check("t1_en_at_done", b0.en, 0);
        tick();
        check("t1_done_width", int'({done0, busy0}), 0);

        // Backpressure on beat 14
        exp0(1, 12); exp0(1, 14); exp0(0, 23); exp0(0, 48);
        go0(4, 1'b0);
        tick();
        b0.ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t2_hold", int'({b0.en, b0.wr, b0.addr}), 128 + 64 + 14);
            if (k < 3) tick();
        end
        b0.ready = 1'b1;
        wait_done0("t2_done_latency", 3);
        tick();

        // Loop with stop
        exp0(1, 12); exp0(1, 14); exp0(1, 12); exp0(1, 14); exp0(1, 12);
        go0(2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_no_wrap_done", done0, 0);
        end
        check("t3_fifth_addr", b0.addr, 12);
        stop0 = 1'b1;
        tick();
        stop0 = 1'b0;
        check("t3_stop_done", int'({done0, b0.en}), 2);
        tick();
        check("t3_done_once", int'({done0, busy0}), 0);

        // num_beats == 0
        go0(0, 1'b0);
        check("t4a_done", int'({done0, b0.en, busy0}), 4);
        tick();
        check("t4a_after", int'({done0, b0.en}), 0);

        // num_beats clamped to DEPTH
        prog0(4, 1, 33); prog0(5, 0, 40); prog0(6, 1, 5); prog0(7, 0, 62);
        exp0(1, 12); exp0(1, 14); exp0(0, 23); exp0(0, 48);
        exp0(1, 33); exp0(0, 40); exp0(1, 5); exp0(0, 62);
        go0(15, 1'b0);
        wait_done0("t4b_clamp_beats", 8);
        tick();

        // Programming lockout during RUN
        exp0(1, 12); exp0(1, 14); exp0(0, 23); exp0(0, 48);
        go0(4, 1'b0);
        prog_idx0 = 3'd1; prog_wr0 = 1'b0; prog_addr0 = 6'd63; prog_we0 = 1'b1;
        tick();
        prog_we0 = 1'b0;
        check("t5_lock_addr", int'({b0.wr, b0.addr}), 64 + 14);
        wait_done0("t5_lock_done", 3);
        tick();

        // Reset mid-run during beat 23
        exp0(1, 12); exp0(1, 14);
        go0(4, 1'b0);
        tick(2);
        check("t5_pre_rst", b0.addr, 23);
        rst = 1'b1;
        tick();
        check("t5_rst_outputs", int'({b0.en, b0.wr, b0.addr, busy0, done0}), 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_no_done_after_rst", done0, 0);
        end
        for (int k = 0; k < 4; k++) exp0(0, 0);
        go0(4, 1'b0);
        wait_done0("t5_replay_cleared", 4);
        tick();

        // Wider instance: 16 beats, last one at 1023
        for (int i = 0; i < 16; i++) begin
            prog1(i, i & 1, (i == 15) ? 1023 : i * 67);
            q1.push_back((i & 1) * 1024 + ((i == 15) ? 1023 : i * 67));
        end
        num1 = 5'd16; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(15);
        check("t6_last_addr", int'({b1.en, b1.addr}), 1024 + 1023);
        tick();
        check("t6_done", int'({done1, b1.en}), 2);

        tick(2);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_stim_sequencer.md
Name: bus_stim_sequencer

Overview:
- Synthesizable, parametrised successor to the fixed en/wr/addr stimulus task.
- Plays a programmable table of bus beats (wr, addr) onto an en/wr/addr interface, one beat per clock. The next beat is presented only after the downstream ready accepts the current one.
- Supports single-shot and loop modes, an abort input, and is programmable at runtime through a write port.
- Sits between test/bring-up control logic and a simple memory-style target.

Parameters:
- ADDR_W, 6, address width of each beat.
- DEPTH, 8, number of table entries; must be >= 2.
- IDX_W, $clog2(DEPTH), table index width (derived).
- CNT_W, $clog2(DEPTH+1), beat-count width (derived).

Ports:
- clk  in  1  single clock; all activity on posedge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  table write strobe.
- prog_idx  in  IDX_W  table entry to write.
- prog_wr  in  1  wr value for the entry.
- prog_addr  in  ADDR_W  addr value for the entry.
- num_beats  in  CNT_W  beats per pass; sampled on start.
- loop_en  in  1  1 = wrap to entry 0 after the last beat; sampled on start.
- start  in  1  launch playback (level, acted on only in IDLE).
- stop  in  1  abort playback.
- ready  in  1  downstream accepts the current beat.
- en  out  1  beat valid.
- wr  out  1  write (1) / read (0) of the current beat.
- addr  out  ADDR_W  address of the current beat.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at the end of a pass or abort.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - en=0, wr=0, addr=0, busy=0, done=0; state=IDLE; index and beat counter=0.
  - Table contents are cleared to 0.
  - Reset asserted mid-RUN: outputs go to 0 on that edge, with no done pulse.
- All outputs are registered.
- FSM states:
  - IDLE: en=0, wr=0, addr=0.
    - start=1 and num_beats!=0 -> RUN; latch n=min(num_beats, DEPTH) and loop_en; en=1 with entry 0 on the following cycle (start at edge N -> en visible after edge N).
    - start=1 and num_beats==0 -> DONE; no beat is issued.
  - RUN: busy=1; en=1, with wr/addr = table[idx].
    - Handshake: a beat is accepted at a posedge with en&&ready. wr/addr must hold stable while ready=0.
    - On acceptance with idx<n-1: idx+1, next beat on the next cycle (no bubble).
    - On acceptance with idx==n-1 and loop latched: idx=0, no bubble, no done pulse.
    - On acceptance with idx==n-1 and no loop: -> DONE.
    - stop=1: -> DONE. If ready was also 1 that cycle, the current beat counts as accepted.
    - start while in RUN is ignored.
  - DONE: en=0, wr=0, addr=0; done=1 for exactly one cycle; -> IDLE unconditionally. start in DONE is ignored.
- Programming port:
  - prog_we writes table[prog_idx] <= {prog_wr, prog_addr} at the posedge, in IDLE or DONE only.
  - prog_we in RUN is ignored, so the playing sequence is never corrupted.
  - prog_idx >= DEPTH is ignored.
- Counting: idx wraps modulo n, not modulo DEPTH. num_beats > DEPTH is clamped to DEPTH.

Decomposition:
- Package bus_stim_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;
  - a parametrised beat struct {wr, addr} (or a beat width constant ADDR_W+1).
- One natural sub-module: bus_stim_table, a DEPTH x (ADDR_W+1) register file. It has a synchronous write port, a combinational read port, and synchronous clear on rst.
- The FSM and counters stay in bus_stim_sequencer.

Test Plan:
1. Single-shot playback:
   - Stimulus: program {wr=1,12},{1,14},{0,23},{0,48}; num_beats=4, loop_en=0, ready=1; pulse start.
   - Required response: addr 12,14,23,48 on 4 consecutive cycles with wr 1,1,0,0; then en=0 and done=1 for one cycle; busy low after.
2. Backpressure:
   - Stimulus: same table; ready=0 for 3 cycles during beat 14.
   - Required response: en=1, wr=1, addr=14 held stable for 4 cycles; the sequence then resumes at 23; done is delayed by 3 cycles.
3. Loop and stop:
   - Stimulus: loop_en=1, num_beats=2; run 5 accepted beats, then assert stop with ready=1.
   - Required response: addr 12,14,12,14,12; done pulses once after stop; no done pulse at the wrap points.
4. Boundaries:
   - Stimulus A: num_beats=0 with start. Required response: done=1 one cycle later, en never rises.
   - Stimulus B: num_beats=15 with DEPTH=8. Required response: exactly 8 beats.
5. Reset mid-operation and programming lockout:
   - Stimulus: assert rst during beat 23.
   - Required response: en/wr/addr=0 on the next edge, no done pulse. A replay after reset outputs addr=0 (table cleared).
   - Stimulus: prog_we during RUN writing idx 1 = {0,63}.
   - Required response: the current pass still shows addr 14.
6. Parameter sweep:
   - Stimulus: ADDR_W=10, DEPTH=16; program addr 1023 at idx 15; play 16 beats.
   - Required response: the last beat shows addr=1023 and all 16 beats appear in order.
